hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have a single clock `clk` and reset `rst`; reset is asynchronous and active-high.
REQ-002 The block SHALL take the following parameters (name, default, meaning):
- REG_AW, 5, register-number width.
- LOAD_LAT, 1, load-use distance in stages; legal values 1 or 2.
- DIV_CYCLES, 32, divider busy cycles; must be at least 2.
- CNT_W, 32, stall-counter width.

REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rsD, rtD  in  REG_AW  source registers of the instruction in D.
- branchD  in  1  the instruction in D is a branch.
- rsE, rtE, writeregE  in  REG_AW  sources and destination of the instruction in E.
- regwriteE, memtoregE  in  1  E writes the GPR file; E is a load.
- div_startE  in  1  E holds a div/divu.
- writeregM  in  REG_AW  destination of the instruction in M.
- regwriteM, memtoregM, write_hiloM  in  1  M writes the GPR file; M is a load; M writes HI/LO.
- mem_stallM  in  1  data-memory wait.
- except_flushM  in  1  exception taken in M.
- writeregW  in  REG_AW  destination of the instruction in W.
- regwriteW  in  1  W writes the GPR file.
- stallF, stallD, stallE, stallM  out  1  hold the stage register.
- flushD, flushE, flushM, flushW  out  1  insert a bubble into the stage register.
- forwardaD, forwardbD  out  1  branch comparator takes the operand from M.
- forwardaE, forwardbE  out  2  ALU operand select.
- forward_hilo_E  out  1  HI/LO forwarded from M.
- div_busy  out  1  divider FSM not IDLE.
- div_doneE  out  1  divide result valid this cycle.
- stall_cnt  out  CNT_W  stall-cycle counter.

Function
REQ-004 A match SHALL require a nonzero register number: register 0 never forwards and never stalls.
REQ-005 forwardaE/forwardbE SHALL encode the operand source as follows, with M taking priority over W:
- 2'b10 when the E source register equals writeregM and regwriteM=1.
- 2'b01 when it equals writeregW and regwriteW=1.
- 2'b00 otherwise.
REQ-006 forwardaD/forwardbD SHALL be 1 when the D source register equals writeregM and regwriteM=1; forward_hilo_E SHALL equal write_hiloM.
REQ-007 Load-use stall (ldstall) SHALL be raised under either condition:
- memtoregE=1 and writeregE matches rsD or rtD.
- LOAD_LAT=2, memtoregM=1 and writeregM matches rsD or rtD.
REQ-008 Branch stall (brstall) SHALL be raised when branchD=1 and either condition holds:
- regwriteE=1 and writeregE matches rsD or rtD.
- memtoregM=1 and writeregM matches rsD or rtD.
REQ-009 The divider FSM SHALL have the states IDLE, BUSY and DONE:
- IDLE->BUSY: div_startE=1 and except_flushM=0; the counter loads DIV_CYCLES-1.
- BUSY: the counter decrements every cycle, including during mem_stallM; at count 0 the next state is DONE.
- DONE: div_doneE=1 for exactly one cycle; next state is IDLE.
- div_busy SHALL be 1 in BUSY and DONE.
REQ-010 divstall SHALL be 1 in IDLE when div_startE=1, and 1 in BUSY; it SHALL be 0 in DONE.
REQ-011 When divstall=1, the block SHALL drive stallF=stallD=stallE=1, stallM=0 and flushM=1; E holds and is not flushed.
REQ-012 When mem_stallM=1, the block SHALL drive stallF=stallD=stallE=stallM=1 and flushW=1, with all other flushes 0.
REQ-013 Otherwise, when ldstall or brstall is raised, the block SHALL drive stallF=stallD=1 and flushE=1.
REQ-014 When except_flushM=1:
- flushD=flushE=flushM=1 and all stalls=0.
- The divider FSM SHALL go to IDLE on the next edge; any pending count is discarded.
REQ-015 Priority SHALL be except_flushM > mem_stallM > divstall > ldstall/brstall; only the winning row drives the stall/flush outputs.
REQ-016 The stall/flush outputs SHALL be combinational from the inputs and FSM state, with no added latency.
REQ-017 stall_cnt SHALL increment by 1 on every edge with stallF=1 and saturate at all-ones.

Reset
REQ-018 While rst=1:
- The divider FSM SHALL be IDLE, the counter 0 and stall_cnt 0.
- div_busy and div_doneE SHALL be 0.
- Other outputs SHALL follow REQ-004..REQ-015 with FSM=IDLE.
REQ-019 Reset asserted during BUSY SHALL abort the divide immediately; no div_doneE pulse SHALL follow.

Structure
REQ-020 The shared package hazard_pkg SHALL hold the following; REG_AW is not a package constant:
- The divider state encoding (IDLE, BUSY, DONE).
- The forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
REQ-021 The divider FSM and its counter SHALL be a sub-module hazard_div_timer; forwarding and priority logic SHALL stay in the top level.

Verification
REQ-022 Forwarding: rsE=rtE=8, with writeregM=8/regwriteM=1 and writeregW=8/regwriteW=1 -> forwardaE=forwardbE=2'b10; with rsE=0 -> forwardaE=2'b00.
REQ-023 Load-use: memtoregE=1, writeregE=9, rtD=9 -> stallF=stallD=flushE=1 for one cycle. With LOAD_LAT=2, the same load in M -> a second stall cycle.
REQ-024 Divide: div_startE=1 with DIV_CYCLES=4 -> stallE=1 for 4 cycles, div_doneE=1 on the 5th cycle, stall_cnt=4.
REQ-025 Abort: except_flushM=1 on the 2nd BUSY cycle -> flushD/E/M=1 and all stalls 0 that cycle; div_busy=0 after the next edge; no div_doneE.
REQ-026 Priority: mem_stallM=1 with brstall active -> stallM=1, flushW=1, flushE=0. rst pulsed mid-BUSY -> div_busy=0 and stall_cnt=0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit.
// Divider state encoding, forward selects and stall/flush bundles.
package hazard_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } divState_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic f;
        logic d;
        logic e;
        logic m;
    } stallVec_t;

    typedef struct packed {
        logic d;
        logic e;
        logic m;
        logic w;
    } flushVec_t;

endpackage

// File: rtl/hazard_div_timer.sv
// Multi-cycle divider sequencer for the hazard unit.
// Tracks IDLE/BUSY/DONE and raises the divide stall request.
module hazard_div_timer
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic divStart,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic stall
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] LAST = CW'(1);

    divState_e      state;
    logic [CW-1:0]  cnt;

    // Sequencer: a taken exception drops any divide in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (divStart) begin
                        state <= DIV_BUSY;
                        cnt   <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                DIV_BUSY: begin
                    cnt <= cnt - LAST;
                    if (cnt == LAST) begin
                        state <= DIV_DONE;
                        done  <= 1'b1;
                    end
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= DIV_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Hold the front end from the request cycle until the result is ready.
    always_comb begin
        stall = 1'b0;
        if (state == DIV_BUSY) begin
            stall = 1'b1;
        end else if (state == DIV_IDLE) begin
            stall = divStart;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, stall and flush control.
// Arbitrates exception, memory wait, divide and load/branch hazards.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 1,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              div_startE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              write_hiloM,
    input  logic              mem_stallM,
    input  logic              except_flushM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              forward_hilo_E,
    output logic              div_busy,
    output logic              div_doneE,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic LOAD_IN_M = (LOAD_LAT == 2);

    logic      ldStall;
    logic      brStall;
    logic      divStall;
    logic      srcHitE;
    logic      srcHitM;
    stallVec_t stl;
    flushVec_t fl;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic regHit(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] dst
    );
        return (src != '0) && (src == dst);
    endfunction

    // The youngest producer (M) wins over W.
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] wrM,
        input logic              rwM,
        input logic [REG_AW-1:0] wrW,
        input logic              rwW
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rwM && regHit(src, wrM)) begin
            sel = FWD_M;
        end else if (rwW && regHit(src, wrW)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    hazard_div_timer #(
        .DIV_CYCLES (DIV_CYCLES)
    ) uDivTimer (
        .clk      (clk),
        .rst      (rst),
        .divStart (div_startE),
        .abort    (except_flushM),
        .busy     (div_busy),
        .done     (div_doneE),
        .stall    (divStall)
    );

    // Operand forwarding into the branch comparator and the ALU.
    always_comb begin
        forwardaD      = regwriteM && regHit(rsD, writeregM);
        forwardbD      = regwriteM && regHit(rtD, writeregM);
        forwardaE      = fwdSel(rsE, writeregM, regwriteM,
                                writeregW, regwriteW);
        forwardbE      = fwdSel(rtE, writeregM, regwriteM,
                                writeregW, regwriteW);
        forward_hilo_E = write_hiloM;
    end

    // Load-use and branch-operand hazards seen by the instruction in D.
    always_comb begin
        srcHitE = regHit(rsD, writeregE) || regHit(rtD, writeregE);
        srcHitM = regHit(rsD, writeregM) || regHit(rtD, writeregM);
        ldStall = (memtoregE && srcHitE)
               || (LOAD_IN_M && memtoregM && srcHitM);
        brStall = branchD
               && ((regwriteE && srcHitE) || (memtoregM && srcHitM));
    end

    // Only the highest-priority condition drives stalls and flushes.
    always_comb begin
        stl = '0;
        fl  = '0;
        if (except_flushM) begin
            fl.d = 1'b1;
            fl.e = 1'b1;
            fl.m = 1'b1;
        end else if (mem_stallM) begin
            stl  = '1;
            fl.w = 1'b1;
        end else if (divStall) begin
            stl.f = 1'b1;
            stl.d = 1'b1;
            stl.e = 1'b1;
            fl.m  = 1'b1;
        end else if (ldStall || brStall) begin
            stl.f = 1'b1;
            stl.d = 1'b1;
            fl.e  = 1'b1;
        end
    end

    assign stallF = stl.f;
    assign stallD = stl.d;
    assign stallE = stl.e;
    assign stallM = stl.m;
    assign flushD = fl.d;
    assign flushE = fl.e;
    assign flushM = fl.m;
    assign flushW = fl.w;

    // Saturating count of cycles the fetch stage was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stl.f && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// Vector table for combinational control plus multi-cycle sequences.
module tb_hazard_ctrl;

    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          branchD, regwriteE, memtoregE, div_startE;
    logic          regwriteM, memtoregM, write_hiloM, mem_stallM;
    logic          except_flushM, regwriteW;

    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushM, flushW;
    logic       forwardaD, forwardbD, forward_hilo_E;
    logic [1:0] forwardaE, forwardbE;
    logic       div_busy, div_doneE;
    logic [3:0] stall_cnt;

    logic        s1F, s1D, s1E, s1M, f1D, f1E, f1M, f1W;
    logic        fa1D, fb1D, hilo1, busy1, done1;
    logic [1:0]  fa1E, fb1E;
    logic [31:0] cnt1;

    hazard_ctrl #(
        .REG_AW(AW), .LOAD_LAT(2), .DIV_CYCLES(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE),
        .div_startE(div_startE), .writeregM(writeregM),
        .regwriteM(regwriteM), .memtoregM(memtoregM),
        .write_hiloM(write_hiloM), .mem_stallM(mem_stallM),
        .except_flushM(except_flushM), .writeregW(writeregW),
        .regwriteW(regwriteW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .flushW(flushW),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .forward_hilo_E(forward_hilo_E), .div_busy(div_busy),
        .div_doneE(div_doneE), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(
        .REG_AW(AW), .LOAD_LAT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE),
        .div_startE(div_startE), .writeregM(writeregM),
        .regwriteM(regwriteM), .memtoregM(memtoregM),
        .write_hiloM(write_hiloM), .mem_stallM(mem_stallM),
        .except_flushM(except_flushM), .writeregW(writeregW),
        .regwriteW(regwriteW),
        .stallF(s1F), .stallD(s1D), .stallE(s1E), .stallM(s1M),
        .flushD(f1D), .flushE(f1E), .flushM(f1M), .flushW(f1W),
        .forwardaD(fa1D), .forwardbD(fb1D),
        .forwardaE(fa1E), .forwardbE(fb1E),
        .forward_hilo_E(hilo1), .div_busy(busy1),
        .div_doneE(done1), .stall_cnt(cnt1)
    );

    typedef struct packed {
        logic [63:0]   name;
        logic [AW-1:0] rsD, rtD;
        logic          branchD;
        logic [AW-1:0] rsE, rtE, wrE;
        logic          rwE, mtrE;
        logic [AW-1:0] wrM;
        logic          rwM, mtrM, hiloM, memStall, exc;
        logic [AW-1:0] wrW;
        logic          rwW;
        logic [3:0]    eStall;
        logic [3:0]    eFlush;
        logic [1:0]    eFwdD;
        logic [1:0]    eFwdaE;
        logic [1:0]    eFwdbE;
        logic          eHilo;
    } vec_t;

    vec_t vecs[$];
    vec_t v;
    int   checks = 0;
    int   failures = 0;
    int   dones;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t b;
        b = '0;
        return b;
    endfunction

    task automatic applyVec(input vec_t a);
        rsD = a.rsD; rtD = a.rtD; branchD = a.branchD;
        rsE = a.rsE; rtE = a.rtE; writeregE = a.wrE;
        regwriteE = a.rwE; memtoregE = a.mtrE;
        writeregM = a.wrM; regwriteM = a.rwM; memtoregM = a.mtrM;
        write_hiloM = a.hiloM; mem_stallM = a.memStall;
        except_flushM = a.exc; writeregW = a.wrW; regwriteW = a.rwW;
    endtask

    function automatic logic [14:0] obs();
        return {stallF, stallD, stallE, stallM,
                flushD, flushE, flushM, flushW,
                forwardaD, forwardbD, forwardaE, forwardbE,
                forward_hilo_E};
    endfunction

    task automatic countDones(input int n);
        dones = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (div_doneE) dones++;
        end
    endtask

    initial begin
        v = blank(); v.name = "fwdM"; v.rsE = 8; v.rtE = 8;
        v.wrM = 8; v.rwM = 1; v.wrW = 8; v.rwW = 1;
        v.eFwdaE = 2'b10; v.eFwdbE = 2'b10; vecs.push_back(v);
        v = blank(); v.name = "fwdR0"; v.rsE = 0; v.rtE = 8;
        v.wrM = 8; v.rwM = 1; v.wrW = 8; v.rwW = 1;
        v.eFwdaE = 2'b00; v.eFwdbE = 2'b10; vecs.push_back(v);
        v = blank(); v.name = "fwdW"; v.rsE = 5; v.rtE = 6;
        v.wrW = 5; v.rwW = 1; v.wrM = 6; v.rwM = 0;
        v.eFwdaE = 2'b01; vecs.push_back(v);
        v = blank(); v.name = "fwdD"; v.rsD = 3; v.rtD = 4;
        v.wrM = 4; v.rwM = 1; v.eFwdD = 2'b01; vecs.push_back(v);
        v = blank(); v.name = "hilo"; v.hiloM = 1; v.eHilo = 1;
        vecs.push_back(v);
        v = blank(); v.name = "ldE"; v.mtrE = 1; v.wrE = 9; v.rtD = 9;
        v.eStall = 4'b1100; v.eFlush = 4'b0100; vecs.push_back(v);
        v = blank(); v.name = "ldM"; v.mtrM = 1; v.rwM = 1;
        v.wrM = 9; v.rtD = 9; v.eStall = 4'b1100;
        v.eFlush = 4'b0100; v.eFwdD = 2'b01; vecs.push_back(v);
        v = blank(); v.name = "ldR0"; v.mtrE = 1; v.wrE = 0;
        vecs.push_back(v);
        v = blank(); v.name = "brE"; v.branchD = 1; v.rwE = 1;
        v.wrE = 7; v.rsD = 7; v.eStall = 4'b1100;
        v.eFlush = 4'b0100; vecs.push_back(v);
        v = blank(); v.name = "brMlw"; v.branchD = 1; v.mtrM = 1;
        v.rwM = 1; v.wrM = 3; v.rsD = 3; v.eStall = 4'b1100;
        v.eFlush = 4'b0100; v.eFwdD = 2'b10; vecs.push_back(v);
        v = blank(); v.name = "memPri"; v.branchD = 1; v.rwE = 1;
        v.wrE = 7; v.rsD = 7; v.memStall = 1;
        v.eStall = 4'b1111; v.eFlush = 4'b0001; vecs.push_back(v);
        v = blank(); v.name = "excPri"; v.mtrE = 1; v.wrE = 9;
        v.rtD = 9; v.memStall = 1; v.exc = 1;
        v.eFlush = 4'b1110; vecs.push_back(v);
        v = blank(); v.name = "brNoHz"; v.branchD = 1; v.rwE = 0;
        v.wrE = 7; v.rsD = 7; vecs.push_back(v);

        applyVec(blank());
        div_startE = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(div_busy), 32'd0);
        check("rst_done", 32'(div_doneE), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Divide with DIV_CYCLES=4
        @(negedge clk);
        div_startE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("div_stall%0d", i),
                  32'({stallF, stallD, stallE, stallM, flushM}),
                  32'b11101);
            @(negedge clk);
        end
        #1;
        check("div_done", 32'({div_doneE, stallE}), 32'b10);
        check("div_cnt", 32'(stall_cnt), 32'd4);
        div_startE = 1'b0;
        @(negedge clk);
        #1;
        check("div_idle", 32'({div_busy, div_doneE}), 32'd0);

        // Exception on the 2nd BUSY cycle
        @(negedge clk);
        div_startE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        except_flushM = 1'b1;
        #1;
        check("abort_ctl", 32'(obs() >> 7), 32'b0000_1110);
        @(negedge clk);
        except_flushM = 1'b0;
        div_startE = 1'b0;
        #1;
        check("abort_busy", 32'(div_busy), 32'd0);
        countDones(6);
        check("abort_nodone", 32'(dones), 32'd0);

        // Combinational vector table
        foreach (vecs[k]) begin
            @(negedge clk);
            applyVec(vecs[k]);
            #1;
            check($sformatf("vec_%s", vecs[k].name), 32'(obs()),
                  32'({vecs[k].eStall, vecs[k].eFlush, vecs[k].eFwdD,
                       vecs[k].eFwdaE, vecs[k].eFwdbE, vecs[k].eHilo}));
        end
        @(negedge clk);
        applyVec(blank());

        // Load in E then the same load in M
        @(negedge clk);
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 9; rtD = 9;
        #1;
        check("ll_e", 32'({stallF, s1F}), 32'b11);
        @(negedge clk);
        memtoregE = 1'b0; regwriteE = 1'b0; writeregE = 0;
        memtoregM = 1'b1; regwriteM = 1'b1; writeregM = 9;
        #1;
        check("ll_m", 32'({stallF, flushE, s1F}), 32'b110);
        @(negedge clk);
        applyVec(blank());

        // Counter saturation
        rst = 1'b1;
        #1;
        rst = 1'b0;
        memtoregE = 1'b1; writeregE = 9; rtD = 9;
        repeat (20) @(negedge clk);
        #1;
        check("sat", 32'(stall_cnt), 32'd15);
        applyVec(blank());

        // Reset in the middle of a divide
        @(negedge clk);
        div_startE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_busy", 32'(div_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_fsm", 32'({div_busy, div_doneE}), 32'd0);
        check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        div_startE = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        countDones(6);
        check("mid_nodone", 32'(dones), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
